// File: rtl/aes_core_scheduler_pkg.sv
// Shared types and constants for the AES-256 core scheduler.
package aes_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2,
    RESP   = 2'd3
  } sched_state_e;

  localparam int AES_BLOCK_W     = 128;
  localparam int AES_KEY_W       = 256;
  localparam int DEFAULT_TIMEOUT = 1023;

endpackage

// File: rtl/aes_core_scheduler_if.sv
// Request, response and core-side signals of the scheduler, bundled as one interface.
interface aes_core_scheduler_if
  import aes_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
);

  logic [NUM_REQ-1:0]                  req_valid_i;
  logic [NUM_REQ-1:0]                  req_ready_o;
  logic [NUM_REQ-1:0][AES_BLOCK_W-1:0] req_plaintext_i;
  logic [NUM_REQ-1:0][AES_KEY_W-1:0]   req_key_i;

  logic                   rsp_valid_o;
  logic                   rsp_ready_i;
  logic [ID_W-1:0]        rsp_id_o;
  logic [AES_BLOCK_W-1:0] rsp_data_o;
  logic                   rsp_err_o;

  logic                   core_en_o;
  logic [AES_BLOCK_W-1:0] core_plaintext_o;
  logic [AES_KEY_W-1:0]   core_key_o;
  logic                   core_busy_i;
  logic                   core_done_i;
  logic [AES_BLOCK_W-1:0] core_ciphertext_i;

  // The scheduler side.
  modport master (
    input  req_valid_i, req_plaintext_i, req_key_i, rsp_ready_i,
           core_busy_i, core_done_i, core_ciphertext_i,
    output req_ready_o, rsp_valid_o, rsp_id_o, rsp_data_o, rsp_err_o,
           core_en_o, core_plaintext_o, core_key_o
  );

  // The request fabric, response consumer and core side.
  modport slave (
    output req_valid_i, req_plaintext_i, req_key_i, rsp_ready_i,
           core_busy_i, core_done_i, core_ciphertext_i,
    input  req_ready_o, rsp_valid_o, rsp_id_o, rsp_data_o, rsp_err_o,
           core_en_o, core_plaintext_o, core_key_o
  );

endinterface

// File: rtl/aes_core_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first valid requester after last_grant, wrapping at NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [ID_W-1:0]    last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               grant_valid
);

  logic [ID_W-1:0] idx;

  // Offset 1 is checked first, so last_grant itself is considered last.
  always_comb begin
    grant       = '0;
    grant_id    = '0;
    grant_valid = 1'b0;
    idx         = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = ID_W'((int'(last_grant) + i) % NUM_REQ);
      if (!grant_valid && valid[idx]) begin
        grant[idx]  = 1'b1;
        grant_id    = idx;
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/aes_core_scheduler.sv
// Shares one AES-256 core among NUM_REQ requesters: round-robin accept, launch, watchdog, tagged response.
module aes_core_scheduler
  import aes_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ),
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input logic clk_i,
  input logic rst_i,
  aes_core_scheduler_if.master bus
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  sched_state_e           state;
  logic [ID_W-1:0]        last_grant;
  logic [ID_W-1:0]        cur_id;
  logic [AES_BLOCK_W-1:0] op_pt;
  logic [AES_KEY_W-1:0]   op_key;
  logic [AES_BLOCK_W-1:0] rsp_data;
  logic                   rsp_err;
  logic [WD_W-1:0]        wd;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_id;
  logic               grant_valid;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .valid       (bus.req_valid_i),
    .last_grant  (last_grant),
    .grant       (grant),
    .grant_id    (grant_id),
    .grant_valid (grant_valid)
  );

  // Ready is only offered from IDLE, so it is naturally a one-cycle pulse.
  assign bus.req_ready_o = (state == IDLE && !rst_i) ? grant : '0;

  assign bus.core_en_o        = (state == LAUNCH) || (state == RUN);
  assign bus.core_plaintext_o = op_pt;
  assign bus.core_key_o       = op_key;

  assign bus.rsp_valid_o = (state == RESP);
  assign bus.rsp_id_o    = cur_id;
  assign bus.rsp_data_o  = rsp_data;
  assign bus.rsp_err_o   = rsp_err;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      last_grant <= ID_W'(NUM_REQ - 1);
      cur_id     <= '0;
      op_pt      <= '0;
      op_key     <= '0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
      wd         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            op_pt      <= bus.req_plaintext_i[grant_id];
            op_key     <= bus.req_key_i[grant_id];
            last_grant <= grant_id;
            cur_id     <= grant_id;
            state      <= LAUNCH;
          end
        end
        LAUNCH: begin
          wd    <= '0;
          state <= RUN;
        end
        RUN: begin
          // Done is tested first so it wins over a coincident timeout.
          if (bus.core_done_i) begin
            rsp_data <= bus.core_ciphertext_i;
            rsp_err  <= 1'b0;
            state    <= RESP;
          end else if (wd == WD_W'(TIMEOUT)) begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
            state    <= RESP;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready_i) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  busy_in_idle: assert property (@(posedge clk_i) disable iff (rst_i)
    (state == IDLE) |-> !bus.core_busy_i);

endmodule

// File: tb/tb_aes_core_scheduler.sv
// Directed bench for aes_core_scheduler with a behavioural AES core of programmable latency.
module tb_aes_core_scheduler;
  import aes_sched_pkg::*;

  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] FIPS_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] FIPS_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] CUS_PT   = 128'h616c656e6b72757468616c656e6b7275;
  localparam logic [255:0] CUS_KEY  = {4{64'h7465737474657374}};
  localparam logic [127:0] CUS_CT   = 128'h4419ce8172f99fa38dc6119260edb3f8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   core_lat = 6;
  logic hang     = 1'b0;
  int   core_cnt;

  always #5 clk = ~clk;

  aes_core_scheduler_if #(.NUM_REQ(4)) bus ();

  aes_core_scheduler #(
    .NUM_REQ (4),
    .TIMEOUT (15)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // Known-answer lookup for the two reference vectors, a simple mix otherwise.
  function automatic logic [127:0] coreModel(input logic [127:0] pt, input logic [255:0] key);
    if (pt == FIPS_PT && key == FIPS_KEY) return FIPS_CT;
    if (pt == CUS_PT && key == CUS_KEY) return CUS_CT;
    return pt ^ key[127:0] ^ key[255:128];
  endfunction

  always @(posedge clk) begin
    if (rst || !bus.core_en_o) begin
      core_cnt         <= 0;
      bus.core_done_i  <= 1'b0;
    end else begin
      core_cnt         <= core_cnt + 1;
      bus.core_done_i  <= !hang && (core_cnt == core_lat - 1);
    end
  end

  assign bus.core_busy_i       = bus.core_en_o;
  assign bus.core_ciphertext_i = coreModel(bus.core_plaintext_o, bus.core_key_o);

  task automatic checkOutput(input string tag, input logic [255:0] actual, input logic [255:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic waitReady(input string tag, input logic [3:0] exp);
    int n = 0;
    #1;
    while (bus.req_ready_o == 4'b0 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput({tag, "_ready"}, 256'(bus.req_ready_o), 256'(exp));
  endtask

  task automatic waitRsp(input string tag, input logic [1:0] exp_id, input logic [127:0] exp_data,
                         input logic exp_err, input int exp_cycles);
    int n = 0;
    @(negedge clk);
    while (!bus.rsp_valid_o && n < 200) begin
      n++;
      @(negedge clk);
    end
    checkOutput({tag, "_rsp_valid"}, 256'(bus.rsp_valid_o), 256'(1'b1));
    checkOutput({tag, "_run_cycles"}, 256'(n), 256'(exp_cycles));
    checkOutput({tag, "_rsp_id"}, 256'(bus.rsp_id_o), 256'(exp_id));
    checkOutput({tag, "_rsp_data"}, 256'(bus.rsp_data_o), 256'(exp_data));
    checkOutput({tag, "_rsp_err"}, 256'(bus.rsp_err_o), 256'(exp_err));
  endtask

  // One complete job from a single requester; returns in RESP with rsp_ready high.
  task automatic applyStimulus(input string tag, input int id, input logic [127:0] pt,
                               input logic [255:0] key, input logic [127:0] exp_data,
                               input logic exp_err, input int exp_cycles);
    bus.req_plaintext_i[id] = pt;
    bus.req_key_i[id]       = key;
    bus.req_valid_i[id]     = 1'b1;
    waitReady(tag, 4'(1 << id));
    @(negedge clk);
    bus.req_valid_i[id] = 1'b0;
    checkOutput({tag, "_launch_en"}, 256'(bus.core_en_o), 256'(1'b1));
    checkOutput({tag, "_launch_ready"}, 256'(bus.req_ready_o), 256'(0));
    checkOutput({tag, "_core_pt"}, 256'(bus.core_plaintext_o), 256'(pt));
    checkOutput({tag, "_core_key"}, bus.core_key_o, key);
    waitRsp(tag, 2'(id), exp_data, exp_err, exp_cycles);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_flags"},
                256'({bus.req_ready_o, bus.rsp_valid_o, bus.rsp_id_o, bus.rsp_err_o, bus.core_en_o}),
                256'(0));
    checkOutput({tag, "_rsp_data"}, 256'(bus.rsp_data_o), 256'(0));
    checkOutput({tag, "_core_pt"}, 256'(bus.core_plaintext_o), 256'(0));
    checkOutput({tag, "_core_key"}, bus.core_key_o, 256'(0));
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    logic [3:0]   exp_oh;
    logic [127:0] exp_ct;
    int           gid;
    bit           seen_rsp;

    bus.req_valid_i     = '0;
    bus.req_plaintext_i = '0;
    bus.req_key_i       = '0;
    bus.rsp_ready_i     = 1'b1;
    for (int r = 0; r < 4; r++) begin
      bus.req_plaintext_i[r] = {4{32'(32'h1000_0001 * (r + 1))}};
      bus.req_key_i[r]       = {8{32'(32'h0a0b_0c0d + r)}};
    end

    repeat (3) @(negedge clk);
    #1;
    checkResetOutputs("reset");
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] FIPS-197 vector");
    applyStimulus("fips", 0, FIPS_PT, FIPS_KEY, FIPS_CT, 1'b0, 6);

    $display("[TB] custom vector");
    applyStimulus("custom", 2, CUS_PT, CUS_KEY, CUS_CT, 1'b0, 6);

    $display("[TB] round-robin fairness");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.req_plaintext_i[0] = 128'h0123456789abcdef0011223344556677;
    bus.req_key_i[0]       = 256'hfeedfacecafebeef;
    bus.req_valid_i = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      gid    = k % 4;
      exp_oh = 4'(1 << gid);
      exp_ct = coreModel(bus.req_plaintext_i[gid], bus.req_key_i[gid]);
      waitReady($sformatf("rr%0d", k), exp_oh);
      @(negedge clk);
      checkOutput($sformatf("rr%0d_pulse", k), 256'(bus.req_ready_o), 256'(0));
      waitRsp($sformatf("rr%0d", k), 2'(gid), exp_ct, 1'b0, 6);
    end
    @(negedge clk);
    bus.req_valid_i = 4'b0000;

    $display("[TB] backpressure");
    @(negedge clk);
    bus.rsp_ready_i = 1'b0;
    bus.req_valid_i = 4'b1010;
    waitReady("bp", 4'b0010);
    @(negedge clk);
    bus.req_valid_i[1] = 1'b0;
    exp_ct = coreModel(bus.req_plaintext_i[1], bus.req_key_i[1]);
    waitRsp("bp", 2'd1, exp_ct, 1'b0, 6);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checkOutput($sformatf("bp_hold%0d", c),
                  {bus.rsp_valid_o, bus.core_en_o, bus.req_ready_o, bus.rsp_id_o, bus.rsp_err_o, bus.rsp_data_o},
                  {1'b1, 1'b0, 4'b0000, 2'd1, 1'b0, exp_ct});
    end
    bus.rsp_ready_i = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("bp_next_ready", 256'(bus.req_ready_o), 256'(4'b1000));
    @(negedge clk);
    bus.req_valid_i[3] = 1'b0;
    exp_ct = coreModel(bus.req_plaintext_i[3], bus.req_key_i[3]);
    waitRsp("bp_next", 2'd3, exp_ct, 1'b0, 6);

    $display("[TB] watchdog timeout");
    hang = 1'b1;
    applyStimulus("timeout", 0, 128'h55, 256'haa, 128'h0, 1'b1, 16);
    hang = 1'b0;

    $display("[TB] done coincident with timeout");
    core_lat = 16;
    applyStimulus("tie", 3, 128'h77, 256'h99, coreModel(128'h77, 256'h99), 1'b0, 16);
    core_lat = 6;

    $display("[TB] mid-job reset");
    bus.req_valid_i[2] = 1'b1;
    waitReady("midrst", 4'b0100);
    @(negedge clk);
    bus.req_valid_i[2] = 1'b0;
    @(negedge clk);
    checkOutput("midrst_in_run", 256'(bus.core_en_o), 256'(1'b1));
    rst = 1'b1;
    @(negedge clk);
    checkResetOutputs("midrst");
    rst = 1'b0;
    seen_rsp = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.rsp_valid_o) seen_rsp = 1'b1;
    end
    checkOutput("midrst_no_rsp", 256'(seen_rsp), 256'(1'b0));
    applyStimulus("after_rst", 1, CUS_PT, CUS_KEY, CUS_CT, 1'b0, 6);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
